lcd_init_sequencer: RTL and testbench



---
 rtl/lcd_seq_pkg.sv | 27 ++
 rtl/lcd_init_rom.sv | 22 ++
 rtl/lcd_init_sequencer.sv | 159 +++++++++++++++
 tb/tb_lcd_init_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_seq_pkg.sv
// Shared constants for the LCD init sequencer: ROM entry layout, entry types and FSM states.
package lcd_seq_pkg;

  localparam int ENTRY_W   = 10;
  localparam int ROM_DEPTH = 16;
  localparam int PTR_W     = $clog2(ROM_DEPTH);

  localparam logic [1:0] T_CMD   = 2'b00;
  localparam logic [1:0] T_DATA  = 2'b01;
  localparam logic [1:0] T_DELAY = 2'b10;
  localparam logic [1:0] T_END   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_GAP,
    S_DELAY,
    S_READY,
    S_ERROR
  } state_t;

  function automatic logic [ENTRY_W-1:0] rom_entry(input logic [1:0] kind, input logic [7:0] payload);
    return {kind, payload};
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Power-up sequence for the panel: combinational pointer-to-entry lookup.
module lcd_init_rom
  import lcd_seq_pkg::*;
(
  input  logic [PTR_W-1:0]   ptr,
  output logic [ENTRY_W-1:0] entry
);

  always_comb begin
    case (ptr)
      4'd0:    entry = rom_entry(T_CMD,   8'h01);  // software reset
      4'd1:    entry = rom_entry(T_DELAY, 8'd150);
      4'd2:    entry = rom_entry(T_CMD,   8'h11);  // sleep out
      4'd3:    entry = rom_entry(T_DELAY, 8'd255);
      4'd4:    entry = rom_entry(T_CMD,   8'h3A);  // pixel format
      4'd5:    entry = rom_entry(T_DATA,  8'h55);
      4'd6:    entry = rom_entry(T_CMD,   8'h29);  // display on
      default: entry = rom_entry(T_END,   8'h00);
    endcase
  end

endmodule

// File: rtl/lcd_init_sequencer.sv
// Plays the ROM init sequence into the SPI LCD transmitter, then forwards host bytes.
// Optional SEND watchdog and ERROR state enabled by defining LCD_SEQ_TIMEOUT_EN.
module lcd_init_sequencer
  import lcd_seq_pkg::*;
#(
  parameter logic [7:0] CLK_DIV    = 8'h18,
  parameter int         DELAY_UNIT = 100000
`ifdef LCD_SEQ_TIMEOUT_EN
  , parameter int       TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_start,
  input  logic       wr_valid,
  input  logic       wr_dc,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       init_done,
  output logic       busy,
  output logic       err,
  output logic [9:0] spi_control,
  output logic [7:0] spi_data,
  input  logic       spi_valid
);

  localparam int CNT_W = $clog2(255 * DELAY_UNIT + 1);

  state_t             state_reg;
  logic [PTR_W-1:0]   ptr_reg;
  logic [CNT_W-1:0]   delay_cnt_reg;
  logic               dc_reg;
  logic               start_reg;
  logic               host_mode_reg;
  logic               valid_q_reg;
  logic               rise_reg;
  logic [ENTRY_W-1:0] entry;
  logic [1:0]         entry_kind;
  logic [7:0]         entry_payload;

  assign entry_kind    = entry[ENTRY_W-1 -: 2];
  assign entry_payload = entry[7:0];
  assign spi_control   = {CLK_DIV, dc_reg, start_reg};

  lcd_init_rom u_rom (
    .ptr   (ptr_reg),
    .entry (entry)
  );

`ifdef LCD_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_reg;
  logic            err_reg;
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      ptr_reg       <= '0;
      delay_cnt_reg <= '0;
      dc_reg        <= 1'b0;
      start_reg     <= 1'b0;
      host_mode_reg <= 1'b0;
      valid_q_reg   <= 1'b0;
      rise_reg      <= 1'b0;
      spi_data      <= 8'h00;
      wr_ready      <= 1'b0;
      init_done     <= 1'b0;
      busy          <= 1'b0;
`ifdef LCD_SEQ_TIMEOUT_EN
      wd_reg        <= '0;
      err_reg       <= 1'b0;
`endif
    end else begin
      // Registered edge: a level already high when SEND is entered never produces a pulse there.
      valid_q_reg <= spi_valid;
      rise_reg    <= spi_valid & ~valid_q_reg;
`ifdef LCD_SEQ_TIMEOUT_EN
      if (state_reg != S_SEND) wd_reg <= '0;
`endif
      case (state_reg)
        S_IDLE: begin
          if (init_start) begin
            ptr_reg       <= '0;
            host_mode_reg <= 1'b0;
            busy          <= 1'b1;
            state_reg     <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (ptr_reg == PTR_W'(ROM_DEPTH - 1) || entry_kind == T_END) begin
            init_done     <= 1'b1;
            host_mode_reg <= 1'b1;
            busy          <= 1'b0;
            wr_ready      <= 1'b1;
            state_reg     <= S_READY;
          end else if (entry_kind == T_DELAY) begin
            delay_cnt_reg <= CNT_W'(entry_payload) * CNT_W'(DELAY_UNIT);
            state_reg     <= S_DELAY;
          end else begin
            spi_data  <= entry_payload;
            dc_reg    <= (entry_kind == T_DATA);
            start_reg <= 1'b1;
            state_reg <= S_SEND;
          end
        end
        S_SEND: begin
          if (rise_reg) begin
            start_reg <= 1'b0;
            state_reg <= S_GAP;
          end
`ifdef LCD_SEQ_TIMEOUT_EN
          else if (wd_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
            start_reg <= 1'b0;
            err_reg   <= 1'b1;
            state_reg <= S_ERROR;
          end else begin
            wd_reg <= wd_reg + WD_W'(1);
          end
`endif
        end
        S_GAP: begin
          if (host_mode_reg) begin
            busy      <= 1'b0;
            wr_ready  <= 1'b1;
            state_reg <= S_READY;
          end else begin
            ptr_reg   <= ptr_reg + PTR_W'(1);
            state_reg <= S_FETCH;
          end
        end
        S_DELAY: begin
          if (delay_cnt_reg == '0) begin
            ptr_reg   <= ptr_reg + PTR_W'(1);
            state_reg <= S_FETCH;
          end else begin
            delay_cnt_reg <= delay_cnt_reg - CNT_W'(1);
          end
        end
        S_READY: begin
          if (wr_valid) begin
            spi_data      <= wr_data;
            dc_reg        <= wr_dc;
            start_reg     <= 1'b1;
            host_mode_reg <= 1'b1;
            wr_ready      <= 1'b0;
            busy          <= 1'b1;
            state_reg     <= S_SEND;
          end
        end
        default: state_reg <= state_reg;  // ERROR is left only through reset
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Scoreboard bench for lcd_init_sequencer with a 20-cycle transmitter model.
`timescale 1ns/1ps
module tb_lcd_init_sequencer;

  localparam int         DELAY_UNIT = 4;
  localparam logic [7:0] CLK_DIV    = 8'h18;
  localparam int         RESP_LAT   = 20;
  localparam int         TO_CYCLES  = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       init_start = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_dc = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, init_done, busy, err;
  logic [9:0] spi_control;
  logic [7:0] spi_data;
  logic       spi_valid;

  lcd_init_sequencer #(
    .CLK_DIV    (CLK_DIV),
    .DELAY_UNIT (DELAY_UNIT)
`ifdef LCD_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES (TO_CYCLES)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .init_start  (init_start),
    .wr_valid    (wr_valid),
    .wr_dc       (wr_dc),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .init_done   (init_done),
    .busy        (busy),
    .err         (err),
    .spi_control (spi_control),
    .spi_data    (spi_data),
    .spi_valid   (spi_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dc;
    logic [7:0] data;
    int         min_gap;
    int         max_gap;
    int         min_high;
    int         max_high;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   silent = 0;
  bit   stale_arm = 0;

  // Panel sequence as a list of (kind, value): 0 cmd, 1 data, 2 delay, 3 end
  int rom_kind[8] = '{0, 2, 0, 2, 0, 1, 0, 3};
  int rom_val[8]  = '{8'h01, 150, 8'h11, 255, 8'h3A, 8'h55, 8'h29, 0};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d want %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic push_init_sequence();
    int acc = 0;
    bit first = 1;
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      if (rom_kind[i] == 3) break;
      if (rom_kind[i] == 2) begin
        acc += rom_val[i] * DELAY_UNIT + 1;
      end else begin
        e.dc       = (rom_kind[i] == 1);
        e.data     = 8'(rom_val[i]);
        e.min_gap  = first ? 0 : ((acc > 1) ? acc : 1);
        e.max_gap  = first ? (1 << 30) : acc + 6;
        e.min_high = RESP_LAT;
        e.max_high = RESP_LAT + 4;
        exp_q.push_back(e);
        first = 0;
        acc   = 0;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_spi_control"}, 32'(spi_control), 32'({CLK_DIV, 2'b00}));
    check({tag, "_spi_data"}, 32'(spi_data), 32'h0);
    check({tag, "_wr_ready"}, 32'(wr_ready), 32'h0);
    check({tag, "_init_done"}, 32'(init_done), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
  endtask

  task automatic pulse_init_start();
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
  endtask

  task automatic wait_init_done(input string tag);
    int n = 0;
    while (!init_done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_init_done"}, 32'(init_done), 32'h1);
    check({tag, "_ready_after_init"}, 32'(wr_ready), 32'h1);
    check({tag, "_busy_after_init"}, 32'(busy), 32'h0);
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!wr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wr_ready_returns", 32'(wr_ready), 32'h1);
  endtask

  task automatic host_write(input logic dc, input logic [7:0] data, input int min_high, input int max_high);
    exp_t e;
    e.dc = dc; e.data = data; e.min_gap = 0; e.max_gap = 1 << 30;
    e.min_high = min_high; e.max_high = max_high;
    check("wr_ready_before_write", 32'(wr_ready), 32'h1);
    exp_q.push_back(e);
    wr_valid = 1'b1; wr_dc = dc; wr_data = data;
    @(negedge clk);
    wr_valid = 1'b0;
    stale_arm = 0;
    check("wr_ready_drops", 32'(wr_ready), 32'h0);
    check("start_after_handshake", 32'(spi_control[0]), 32'h1);
    check("busy_in_send", 32'(busy), 32'h1);
  endtask

  // Transmitter model: pulses spi_valid RESP_LAT cycles after start rises.
  initial begin : xmit
    bit seen = 0;
    bit stale_act = 0;
    spi_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!spi_control[0]) begin
        seen = 0;
        if (stale_arm && !stale_act) begin
          spi_valid = 1'b1;
          stale_act = 1;
        end
      end else if (!seen) begin
        seen = 1;
        if (!silent) begin
          if (stale_act) begin
            repeat (RESP_LAT) @(negedge clk);
            spi_valid = 1'b0;
            repeat (3) @(negedge clk);
            spi_valid = 1'b1;
            stale_act = 0;
          end else begin
            repeat (RESP_LAT - 1) @(negedge clk);
            spi_valid = 1'b1;
          end
          @(negedge clk);
          spi_valid = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    bit   prev = 0;
    bit   have = 0;
    int   high_cnt = 0;
    int   low_cnt = 0;
    exp_t cur;
    forever begin
      @(negedge clk);
      if (spi_control[0] && !prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          have = 0;
          $display("FAIL unexpected_byte: got dc=%0d data=%02h want none", spi_control[1], spi_data);
        end else begin
          cur  = exp_q.pop_front();
          have = 1;
          $display("byte dc=%0d data=%02h gap=%0d", spi_control[1], spi_data, low_cnt);
          check("byte_data", 32'(spi_data), 32'(cur.data));
          check("byte_dc", 32'(spi_control[1]), 32'(cur.dc));
          check("clk_div", 32'(spi_control[9:2]), 32'(CLK_DIV));
          check_range("gap_before_byte", low_cnt, cur.min_gap, cur.max_gap);
        end
        high_cnt = 1;
      end else if (spi_control[0]) begin
        high_cnt++;
      end else begin
        if (prev && have) check_range("start_high_cycles", high_cnt, cur.min_high, cur.max_high);
        if (prev) have = 0;
        low_cnt = prev ? 1 : low_cnt + 1;
      end
      prev = spi_control[0];
    end
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
    @(negedge clk);

    // ROM init path, with ignored init_start pulses while busy
    push_init_sequence();
    pulse_init_start();
    check("start_low_in_fetch", 32'(spi_control[0]), 32'h0);
    check("busy_after_init_start", 32'(busy), 32'h1);
    @(negedge clk);
    check("start_two_cycles", 32'(spi_control[0]), 32'h1);
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(30, 400)) @(negedge clk);
      if (i == 0) check("init_done_early", 32'(init_done), 32'h0);
      pulse_init_start();
    end
    wait_init_done("init");

    // Host writes: fixed A5, one ignored wr_valid while busy, stale level, then random
    host_write(1'b1, 8'hA5, RESP_LAT, RESP_LAT + 4);
    wr_valid = 1'b1; wr_dc = 1'b0; wr_data = 8'h3C;
    repeat (3) @(negedge clk);
    wr_valid = 1'b0;
    wait_ready();

    stale_arm = 1;
    repeat (3) @(negedge clk);
    host_write(1'($urandom_range(0, 1)), 8'($urandom), RESP_LAT + 4, RESP_LAT + 8);
    wait_ready();

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      host_write(1'($urandom_range(0, 1)), 8'($urandom), RESP_LAT, RESP_LAT + 4);
      if ($urandom_range(0, 1) == 1) pulse_init_start();
      wait_ready();
    end
    check("queue_drained_host", 32'(exp_q.size()), 32'h0);

    // Asynchronous reset in the middle of the first DELAY, then a clean restart
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push_init_sequence();
    pulse_init_start();
    repeat (100) @(negedge clk);
    check("busy_in_delay", 32'(busy), 32'h1);
    check("start_low_in_delay", 32'(spi_control[0]), 32'h0);
    #2 reset = 1'b0;
    #1 check_reset_values("async_reset");
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push_init_sequence();
    pulse_init_start();
    wait_init_done("restart");

`ifdef LCD_SEQ_TIMEOUT_EN
    begin
      int n = 0;
      silent = 1;
      host_write(1'b0, 8'($urandom), TO_CYCLES, TO_CYCLES + 2);
      while (!err && n < 80) begin
        @(negedge clk);
        n++;
      end
      check_range("timeout_cycles", n, TO_CYCLES, TO_CYCLES + 1);
      check("timeout_err", 32'(err), 32'h1);
      check("timeout_start_low", 32'(spi_control[0]), 32'h0);
      wr_valid = 1'b1; wr_data = 8'h77;
      repeat (20) @(negedge clk);
      wr_valid = 1'b0;
      check("timeout_wr_ready_low", 32'(wr_ready), 32'h0);
      check("timeout_err_sticky", 32'(err), 32'h1);
      silent = 0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("err_cleared_by_reset", 32'(err), 32'h0);
    end
`endif

    repeat (5) @(negedge clk);
    check("queue_empty_at_end", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : global_guard
    #1000000;
    $display("FAIL global_timeout: got no finish want finish within 1 ms");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
